// File: rtl/screen_blitter.sv
// screen_blitter
// Full-screen image drawer for the VGA path. A start pulse sweeps every pixel
// of an SCR_W x SCR_H frame in raster order. Each address goes out to all of
// the external screen ROMs. A delay line carries the pixel coordinates until
// the ROM data is ready, and a registered output stage then hands
// x/y/colour/plot to the VGA adapter.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_resetn         synchronous reset, active-high (1 = reset)
//   i_start          one-cycle request to draw a frame (only honoured in IDLE)
//   i_abort          cancel an in-progress draw (SWEEP/DRAIN only)
//   i_fill_mode      0 = draw ROM image, 1 = solid fill with i_fill_colour
//   i_fill_colour    fill colour
//   i_screen_select  ROM image index, latched at start
//   o_rom_addr       address broadcast to all screen ROMs
//   i_rom_q          concatenated ROM outputs, screen i at [i*COLOUR_W +: COLOUR_W]
//   o_x, o_y         pixel coordinates
//   o_colour         pixel colour
//   o_plot           x/y/colour valid, write pixel
//   o_busy           draw in progress, including pipeline drain
//   o_done           one-cycle pulse at completion
module screen_blitter #(
    parameter int SCR_W       = 160,
    parameter int SCR_H       = 120,
    parameter int ADDR_W      = 15,
    parameter int COORD_W     = 10,
    parameter int COLOUR_W    = 2,
    parameter int NUM_SCREENS = 3,
    parameter int SEL_W       = 2,
    parameter int ROM_LAT     = 1,
    parameter int TRANSP_EN   = 0,
    parameter int TRANSP_KEY  = 0
) (
    input  logic                            i_clk,
    input  logic                            i_resetn,
    input  logic                            i_start,
    input  logic                            i_abort,
    input  logic                            i_fill_mode,
    input  logic [COLOUR_W-1:0]             i_fill_colour,
    input  logic [SEL_W-1:0]                i_screen_select,
    output logic [ADDR_W-1:0]               o_rom_addr,
    input  logic [NUM_SCREENS*COLOUR_W-1:0] i_rom_q,
    output logic [COORD_W-1:0]              o_x,
    output logic [COORD_W-1:0]              o_y,
    output logic [COLOUR_W-1:0]             o_colour,
    output logic                            o_plot,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int NPIX  = SCR_W * SCR_H;
    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, FINISH} state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [COORD_W-1:0]   r_xCount;
    logic [COORD_W-1:0]   r_yCount;
    logic [CNT_W-1:0]     r_drainCount;
    logic                 r_fill;
    logic [COLOUR_W-1:0]  r_fillColour;
    logic [SEL_W-1:0]     r_sel;

    logic [COORD_W-1:0]   r_dlX [ROM_LAT];
    logic [COORD_W-1:0]   r_dlY [ROM_LAT];
    logic [ROM_LAT-1:0]   r_dlValid;

    logic                 w_abortNow;
    logic                 w_tailValid;
    logic [COLOUR_W-1:0]  w_romColour;
    logic [COLOUR_W-1:0]  w_pixColour;
    logic                 w_transparent;

    assign w_abortNow  = i_abort && ((r_state == SWEEP) || (r_state == DRAIN));
    assign w_tailValid = r_dlValid[ROM_LAT-1];
    assign o_rom_addr  = r_addr;

    // Main sequencer. The draw settings are latched at start so that input
    // changes during a frame cannot affect it. The x/y counters wrap
    // alongside the linear address, so no divider is needed. DRAIN waits
    // ROM_LAT cycles so the last pixel leaves the delay line before done.
    always_ff @(posedge i_clk) begin
        if (i_resetn) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_xCount     <= '0;
            r_yCount     <= '0;
            r_drainCount <= '0;
            r_fill       <= 1'b0;
            r_fillColour <= '0;
            r_sel        <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_fill       <= i_fill_mode;
                        r_fillColour <= i_fill_colour;
                        r_sel        <= i_screen_select;
                        r_addr       <= '0;
                        r_xCount     <= '0;
                        r_yCount     <= '0;
                        o_busy       <= 1'b1;
                        r_state      <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (i_abort) begin
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_addr == ADDR_W'(NPIX - 1)) begin
                        r_drainCount <= '0;
                        r_state      <= DRAIN;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                        if (r_xCount == COORD_W'(SCR_W - 1)) begin
                            r_xCount <= '0;
                            r_yCount <= r_yCount + 1'b1;
                        end else begin
                            r_xCount <= r_xCount + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (i_abort) begin
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_drainCount == CNT_W'(ROM_LAT - 1)) begin
                        r_state <= FINISH;
                    end else begin
                        r_drainCount <= r_drainCount + 1'b1;
                    end
                end
                FINISH: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Coordinate delay line. It shifts every cycle, and a valid entry is
    // pushed only while sweeping. The tail lines up with the ROM data for
    // the same address. An abort clears the valid bits so that no stale
    // pixel plots after the draw is cancelled.
    always_ff @(posedge i_clk) begin
        if (i_resetn || w_abortNow) begin
            r_dlValid <= '0;
        end else begin
            r_dlValid[0] <= (r_state == SWEEP);
            r_dlX[0]     <= r_xCount;
            r_dlY[0]     <= r_yCount;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_dlValid[i] <= r_dlValid[i-1];
                r_dlX[i]     <= r_dlX[i-1];
                r_dlY[i]     <= r_dlY[i-1];
            end
        end
    end

    // Screen mux. A latched index that does not name a real screen falls
    // through to black.
    always_comb begin
        w_romColour = '0;
        for (int i = 0; i < NUM_SCREENS; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_romColour = i_rom_q[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign w_pixColour   = r_fill ? r_fillColour : w_romColour;
    assign w_transparent = (TRANSP_EN != 0) && !r_fill &&
                           (w_pixColour == COLOUR_W'(TRANSP_KEY));

    // Registered output stage. A transparent pixel still updates x/y/colour
    // but does not plot. When no valid pixel is present, the coordinates
    // and colour hold their last values.
    always_ff @(posedge i_clk) begin
        if (i_resetn) begin
            o_x      <= '0;
            o_y      <= '0;
            o_colour <= '0;
            o_plot   <= 1'b0;
        end else if (w_abortNow) begin
            o_plot <= 1'b0;
        end else begin
            o_plot <= w_tailValid && !w_transparent;
            if (w_tailValid) begin
                o_x      <= r_dlX[ROM_LAT-1];
                o_y      <= r_dlY[ROM_LAT-1];
                o_colour <= w_pixColour;
            end
        end
    end

endmodule

// File: tb/tb_screen_blitter.sv
// tb_screen_blitter
// Self-checking bench for screen_blitter using a 4x3 frame. Three instances
// share one set of stimulus:
//   dut 0: ROM_LAT=1, no transparency
//   dut 1: ROM_LAT=2, no transparency
//   dut 2: ROM_LAT=1, transparency on colour 0
// The expected value for each cycle comes from frame arithmetic. Pixel n
// plots ROM_LAT+1 cycles after it is addressed, busy covers the sweep plus
// the drain, and done follows one cycle after the last plot.
module tb_screen_blitter;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int N    = W * H;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic             start;
    logic             abort;
    logic             fillMode;
    logic [1:0]       fillColour;
    logic [1:0]       screenSelect;

    logic [2:0][14:0] romAddrV;
    logic [2:0][5:0]  romQV;
    logic [2:0][9:0]  xV;
    logic [2:0][9:0]  yV;
    logic [2:0][1:0]  colourV;
    logic [2:0]       plotV;
    logic [2:0]       busyV;
    logic [2:0]       doneV;
    logic [5:0]       romStageB;

    logic [1:0]       romMem [3][16];
    logic             expFill;
    logic [1:0]       expFillCol;
    logic [1:0]       expSel;

    int checks   = 0;
    int failures = 0;

    screen_blitter #(.SCR_W(W), .SCR_H(H), .ROM_LAT(1), .TRANSP_EN(0), .TRANSP_KEY(0)) dutA (
        .i_clk(clk), .i_resetn(resetn), .i_start(start), .i_abort(abort),
        .i_fill_mode(fillMode), .i_fill_colour(fillColour), .i_screen_select(screenSelect),
        .o_rom_addr(romAddrV[0]), .i_rom_q(romQV[0]), .o_x(xV[0]), .o_y(yV[0]),
        .o_colour(colourV[0]), .o_plot(plotV[0]), .o_busy(busyV[0]), .o_done(doneV[0]));

    screen_blitter #(.SCR_W(W), .SCR_H(H), .ROM_LAT(2), .TRANSP_EN(0), .TRANSP_KEY(0)) dutB (
        .i_clk(clk), .i_resetn(resetn), .i_start(start), .i_abort(abort),
        .i_fill_mode(fillMode), .i_fill_colour(fillColour), .i_screen_select(screenSelect),
        .o_rom_addr(romAddrV[1]), .i_rom_q(romQV[1]), .o_x(xV[1]), .o_y(yV[1]),
        .o_colour(colourV[1]), .o_plot(plotV[1]), .o_busy(busyV[1]), .o_done(doneV[1]));

    screen_blitter #(.SCR_W(W), .SCR_H(H), .ROM_LAT(1), .TRANSP_EN(1), .TRANSP_KEY(0)) dutC (
        .i_clk(clk), .i_resetn(resetn), .i_start(start), .i_abort(abort),
        .i_fill_mode(fillMode), .i_fill_colour(fillColour), .i_screen_select(screenSelect),
        .o_rom_addr(romAddrV[2]), .i_rom_q(romQV[2]), .o_x(xV[2]), .o_y(yV[2]),
        .o_colour(colourV[2]), .o_plot(plotV[2]), .o_busy(busyV[2]), .o_done(doneV[2]));

    function automatic logic [5:0] romRead(input logic [14:0] a);
        logic [5:0] r;
        for (int s = 0; s < 3; s++) r[s*2 +: 2] = romMem[s][a[3:0]];
        return r;
    endfunction

    // Synchronous screen ROMs, one or two register stages deep to match
    // each instance's ROM_LAT.
    always @(posedge clk) begin
        romQV[0]  <= romRead(romAddrV[0]);
        romStageB <= romRead(romAddrV[1]);
        romQV[1]  <= romStageB;
        romQV[2]  <= romRead(romAddrV[2]);
    end

    function automatic int latOf(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic bit transpOf(input int d);
        return d == 2;
    endfunction

    // Colour that pixel n must carry under the settings latched at start.
    function automatic logic [1:0] expColour(input int n);
        if (expFill) return expFillCol;
        if (expSel > 2'd2) return 2'b00;
        return romMem[expSel][n];
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s dut%0d: observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // Check every instance in frame cycle k. killMode is 0 for a normal
    // frame, 1 after an abort, and 2 after a reset.
    task automatic checkOutput(input int k, input int killMode);
        for (int d = 0; d < NDUT; d++) begin
            int         lat;
            int         n;
            logic [1:0] c;
            lat = latOf(d);
            if (killMode != 0) begin
                chk("plot_killed", d, 32'(plotV[d]), 32'd0);
                chk("busy_killed", d, 32'(busyV[d]), 32'd0);
                chk("done_killed", d, 32'(doneV[d]), 32'd0);
                if (killMode == 2) begin
                    chk("x_reset", d, 32'(xV[d]), 32'd0);
                    chk("y_reset", d, 32'(yV[d]), 32'd0);
                    chk("colour_reset", d, 32'(colourV[d]), 32'd0);
                    chk("rom_addr_reset", d, 32'(romAddrV[d]), 32'd0);
                end
            end else begin
                chk("busy", d, 32'(busyV[d]), 32'(k <= N + lat));
                chk("done", d, 32'(doneV[d]), 32'(k == N + lat + 1));
                if (k < N) chk("rom_addr", d, 32'(romAddrV[d]), k);
                n = k - lat - 1;
                if (n >= 0 && n < N) begin
                    c = expColour(n);
                    chk("x", d, 32'(xV[d]), n % W);
                    chk("y", d, 32'(yV[d]), n / W);
                    chk("colour", d, 32'(c), 32'(colourV[d]) );
                    chk("plot", d, 32'(plotV[d]), 32'(!(transpOf(d) && !expFill && c == 2'b00)));
                end else begin
                    chk("plot_idle", d, 32'(plotV[d]), 32'd0);
                end
            end
        end
    endtask

    // Start one frame and check it cycle by cycle. Halfway through the frame
    // the draw inputs are changed to prove they are latched. Stray starts
    // are issued mid-sweep and in the FINISH/DRAIN window. An optional abort
    // or reset is applied after the check at the given cycle.
    task automatic applyStimulus(input bit fm, input logic [1:0] fc, input logic [1:0] sel,
                                 input bit abortWithStart, input int abortAt, input int resetAt);
        int killMode;
        @(negedge clk);
        fillMode     = fm;
        fillColour   = fc;
        screenSelect = sel;
        start        = 1'b1;
        abort        = abortWithStart;
        expFill      = fm;
        expFillCol   = fc;
        expSel       = sel;
        killMode     = 0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            start  = 1'b0;
            abort  = 1'b0;
            resetn = 1'b0;
            if (abortAt >= 0 && k > abortAt) killMode = 1;
            if (resetAt >= 0 && k > resetAt) killMode = 2;
            checkOutput(k, killMode);
            if (k == 2) begin
                screenSelect = sel ^ 2'b01;
                fillColour   = ~fc;
                fillMode     = ~fm;
            end
            if (abortAt < 0 && resetAt < 0 && (k == 5 || k == N + 1)) start = 1'b1;
            if (k == abortAt) abort = 1'b1;
            if (k == resetAt) resetn = 1'b1;
            if (k == 18) abort = 1'b1;
        end
    endtask

    initial begin
        resetn       = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        fillMode     = 1'b0;
        fillColour   = 2'b00;
        screenSelect = 2'b00;
        expFill      = 1'b0;
        expFillCol   = 2'b00;
        expSel       = 2'b00;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 16; i++) romMem[s][i] = 2'(i % 4);

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput(0, 2);
        resetn = 1'b0;

        $display("[TB] ROM mode, screen 1, colour = addr mod 4");
        applyStimulus(1'b0, 2'b00, 2'd1, 1'b0, -1, -1);

        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 16; i++) romMem[s][i] = 2'($urandom);

        $display("[TB] solid fill colour 3");
        applyStimulus(1'b1, 2'b11, 2'd0, 1'b0, -1, -1);

        $display("[TB] reset mid-sweep at pixel 5, then redraw");
        applyStimulus(1'b0, 2'($urandom), 2'd2, 1'b0, -1, 5);
        applyStimulus(1'b0, 2'($urandom), 2'd1, 1'b0, -1, -1);

        $display("[TB] abort at rom_addr 6, then redraw");
        applyStimulus(1'b0, 2'($urandom), 2'd0, 1'b0, 6, -1);
        applyStimulus(1'b0, 2'($urandom), 2'd2, 1'b0, -1, -1);

        $display("[TB] invalid screen 3 with abort alongside start");
        applyStimulus(1'b0, 2'($urandom), 2'd3, 1'b1, -1, -1);

        $display("[TB] randomized frames");
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 3; s++)
                for (int i = 0; i < 16; i++) romMem[s][i] = 2'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom_range(0, 3)),
                          1'b0, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/screen_blitter.md
Name: screen_blitter

Overview:
- Parametrised full-screen image drawer for the VGA path.
- On a start pulse it sweeps every pixel of a SCR_W x SCR_H frame, in raster order.
- It issues addresses to the external screen ROMs and selects one ROM's colour by a latched screen index.
- It emits latency-aligned x/y/colour/plot strobes to the VGA adapter.
- Adds three things the current drawer lacks:
  - busy/done handshake, with abort;
  - solid-fill mode for screen clears;
  - optional transparent-colour plot suppression.

Parameters:
SCR_W, 160, frame width in pixels
SCR_H, 120, frame height in pixels
ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= SCR_W*SCR_H
COORD_W, 10, x and y output width
COLOUR_W, 2, colour width per pixel
NUM_SCREENS, 3, number of ROM images muxed
SEL_W, 2, screen_select width
ROM_LAT, 1, ROM read latency in cycles (>=1)
TRANSP_EN, 0, 1 = suppress plot when colour == TRANSP_KEY (ROM mode only)
TRANSP_KEY, 0, transparent colour value

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  synchronous reset, active-high (1 = reset); named per codebase convention
start  in  1  one-cycle request to draw a frame
abort  in  1  cancel an in-progress draw
fill_mode  in  1  0 = draw ROM image, 1 = solid fill with fill_colour
fill_colour  in  COLOUR_W  fill colour
screen_select  in  SEL_W  ROM image index
rom_addr  out  ADDR_W  address broadcast to all screen ROMs
rom_q  in  NUM_SCREENS*COLOUR_W  concatenated ROM outputs; screen i at bits [i*COLOUR_W +: COLOUR_W]
x  out  COORD_W  pixel x
y  out  COORD_W  pixel y
colour  out  COLOUR_W  pixel colour
plot  out  1  x/y/colour valid, write pixel
busy  out  1  draw in progress, including pipeline drain
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset, while resetn=1 at a clock edge:
  - state=IDLE;
  - rom_addr, x, y, colour, plot, busy, done all 0;
  - pipeline valid bits cleared.
  - Reset takes priority over all inputs, including mid-draw; no done is issued.
- States are IDLE, SWEEP, DRAIN, FINISH.
- IDLE:
  - start=1 latches fill_mode, fill_colour and screen_select.
  - Then: counters x_c=y_c=addr=0, busy=1, go to SWEEP.
  - start in any other state is ignored.
- SWEEP:
  - Each cycle presents rom_addr=addr and pushes {x_c, y_c, valid=1} into a delay line of depth ROM_LAT.
  - Counter advance: addr+1; x_c+1, wrapping to 0 at SCR_W-1 with y_c+1.
  - No divide or modulo is used.
  - After the push for addr = SCR_W*SCR_H-1, go to DRAIN.
- DRAIN:
  - Pushes valid=0 until the delay line is empty (ROM_LAT cycles).
  - Then go to FINISH.
- FINISH:
  - done=1 for exactly one cycle, busy=0, back to IDLE.
  - A start in the FINISH cycle is ignored.
- Output stage is registered. For pixel n addressed at SWEEP cycle t0+n, at cycle t0+n+ROM_LAT+1:
  - plot=1, x=n mod SCR_W, y=n div SCR_W;
  - colour = latched fill_colour (fill mode), else the rom_q slice of the latched screen.
- Invalid screen index: if the latched screen_select >= NUM_SCREENS, colour=0 (black); the sweep still completes.
- Transparency:
  - Applies only when TRANSP_EN=1, ROM mode, and colour == TRANSP_KEY.
  - plot=0 for that pixel; x/y/colour still update.
- Abort:
  - abort=1 in SWEEP or DRAIN: next cycle state=IDLE, delay line flushed, plot=0, busy=0, no done.
  - abort in IDLE or FINISH has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Timing: busy rises the cycle after start and falls with the done pulse.
- Total latency from start to done = SCR_W*SCR_H + ROM_LAT + 2 cycles.
- Outputs hold their last values when plot=0; only plot carries meaning then.

Test Plan (SCR_W=4, SCR_H=3, ROM_LAT=1 unless stated):
1. Reset mid-sweep at pixel 5 -> next cycle all outputs 0, state IDLE; a new start then draws from (0,0).
2. ROM mode, screen_select=1, ROM model q=addr[1:0] per screen -> 12 plots in raster order (0,0)..(3,2) with colour=addr%4; rom_addr 0..11 each held one cycle; done one cycle at start+15; busy high for exactly 14 cycles.
3. fill_mode=1, fill_colour=2'b11; screen_select changed mid-draw -> 12 plots all colour 3, rom_q ignored; change has no effect.
4. abort asserted when rom_addr=6 -> next cycle plot=0, busy=0; no done; restart yields full 12-pixel frame.
5. TRANSP_EN=1, TRANSP_KEY=0 -> plot suppressed exactly for pixels with ROM colour 0 (addr 0, 4, 8); others plot.
6. ROM_LAT=2, screen_select=3 (invalid) -> 12 plots colour 0, first plot 3 cycles after first rom_addr; done at start+16; start while busy ignored.
